// File: rtl/demux_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : demux_route_sequencer
//  Purpose  : Framing stage in front of a 1-to-4 demultiplexer. Takes a
//             parallel word and a 2-bit destination over valid/ready. Each
//             word is sent as a serial burst on d:
//               SETUP(0), START(1), DATA MSB-first, GUARD(0).
//             The selects s0/s1 stay fixed for the whole frame, so only the
//             addressed demux output can see a 1.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid / in_ready / in_data[DATA_W] / in_dest[2] : input handshake
//             d, s0, s1    : demux drive (s0 = in_dest[1], s1 = in_dest[0])
//             busy         : frame in progress
//             done         : one-cycle pulse during GUARD
//             frame_cnt    : completed frames, wraps at 16 bits
//  Revision : 1.0  initial release
// ============================================================================
module demux_route_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              d,
  output logic              s0,
  output logic              s1,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_bitcnt;
  logic               r_d;
  logic               r_s0;
  logic               r_s1;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;
  logic [15:0]        r_frame_cnt;

  // r_ready is only ever high in IDLE and GUARD, so this also encodes
  // "we are in a state that may accept".
  logic w_accept;
  assign w_accept = in_valid && r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_d         <= 1'b0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Selects only ever change here, and d is 0 in both the state we
        // leave (IDLE/GUARD) and the state we enter (SETUP).
        r_state <= S_SETUP;
        r_shift <= in_data;
        r_s0    <= in_dest[1];
        r_s1    <= in_dest[0];
        r_d     <= 1'b0;
        r_busy  <= 1'b1;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_d     <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
          S_SETUP: begin
            r_d     <= 1'b1;
            r_state <= S_START;
          end
          S_START: begin
            // First data bit leaves on the START->DATA edge.
            r_d      <= r_shift[DATA_W-1];
            r_shift  <= r_shift << 1;
            r_bitcnt <= '0;
            r_state  <= S_DATA;
          end
          S_DATA: begin
            if (r_bitcnt == c_LAST) begin
              r_d         <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              // Raised on GUARD entry so a waiting word is taken on the
              // GUARD->SETUP edge: one frame every DATA_W+3 cycles.
              r_ready     <= 1'b1;
              r_state     <= S_GUARD;
            end else begin
              r_d      <= r_shift[DATA_W-1];
              r_shift  <= r_shift << 1;
              r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
          end
          S_GUARD: begin
            r_d     <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_d     <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_ready;
  assign d         = r_d;
  assign s0        = r_s0;
  assign s1        = r_s1;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_route_sequencer
//  Purpose  : Directed self-checking bench for demux_route_sequencer
//             (DATA_W = 8). One task per scenario, inline comparisons.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_demux_route_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        d;
  logic        s0;
  logic        s1;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Hand-derived d sequences from SETUP through GUARD.
  int exp_a5[11] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0};            // dest 2, 8'hA5
  int exp_b2b[22] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0,           // 8'hFF
                      0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};          // 8'h01
  int exp_5a[11] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0};            // 8'h5A

  demux_route_sequencer #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .d         (d),
    .s0        (s0),
    .s1        (s1),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_dest  = 2'd0;
    #2;
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL reset_d got %b want 0", d); end
    checks++; if ({s0, s1} !== 2'b00) begin errors++; $display("FAIL reset_sel got %b want 00", {s0, s1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", frame_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    logic [3:0] seen;
    seen     = 4'b0000;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_dest  = 2'd2;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) begin
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b want 0", in_ready); end
      end
      if (d === 1'b1) seen[{s0, s1}] = 1'b1;
      checks++; if (d !== exp_a5[i][0]) begin errors++; $display("FAIL single_d[%0d] got %b want %0d", i, d, exp_a5[i]); end
      checks++; if ({s0, s1} !== 2'b10) begin errors++; $display("FAIL single_sel[%0d] got %b want 10", i, {s0, s1}); end
      checks++; if (done !== (i == 10)) begin errors++; $display("FAIL single_done[%0d] got %b want %b", i, done, (i == 10)); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", frame_cnt); end
    checks++; if (seen !== 4'b0100) begin errors++; $display("FAIL single_route got %b want 0100", seen); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_idle_done got %b want 0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want_sel;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_dest  = 2'd0;
    for (int n = 0; n < 22; n++) begin
      tick();
      if (n == 0) begin
        // Second word is presented while the first frame is still running.
        in_data = 8'h01;
        in_dest = 2'd3;
      end
      if (n >= 12) begin
        in_data = 8'($urandom);
        in_dest = 2'($urandom);
      end
      want_sel = (n >= 11) ? 2'b11 : 2'b00;
      checks++; if (d !== exp_b2b[n][0]) begin errors++; $display("FAIL b2b_d[%0d] got %b want %0d", n, d, exp_b2b[n]); end
      checks++; if ({s0, s1} !== want_sel) begin errors++; $display("FAIL b2b_sel[%0d] got %b want %b", n, {s0, s1}, want_sel); end
      checks++; if (done !== (n == 10 || n == 21)) begin errors++; $display("FAIL b2b_done[%0d] got %b want %b", n, done, (n == 10 || n == 21)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %b want 1", n, busy); end
      if (n == 11) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got %b want 0", in_ready); end
        in_valid = 1'b0;
      end
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt got %0d want 3", frame_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom);
      in_dest = 2'($urandom);
      tick();
      checks++; if (d !== 1'b0) begin errors++; $display("FAIL stall_d[%0d] got %b want 0", i, d); end
      checks++; if ({s0, s1} !== 2'b11) begin errors++; $display("FAIL stall_sel[%0d] got %b want 11", i, {s0, s1}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy[%0d] got %b want 0", i, busy); end
      checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt[%0d] got %0d want 3", i, frame_cnt); end
    end
  endtask

  task automatic test_reset_mid_data();
    in_valid = 1'b1;
    in_data  = 8'h10;     // 4th data bit is the only 1
    in_dest  = 2'd1;
    tick();               // SETUP
    in_valid = 1'b0;
    tick();               // START
    for (int i = 0; i < 4; i++) tick();
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL mid_bit4 got %b want 1", d); end
    rst_n = 1'b0;
    #1;
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL mid_rst_d got %b want 0", d); end
    checks++; if ({s0, s1} !== 2'b00) begin errors++; $display("FAIL mid_rst_sel got %b want 00", {s0, s1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", frame_cnt); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done[%0d] got %b want 0", i, done); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_dest  = 2'd3;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) in_valid = 1'b0;
      checks++; if (d !== exp_5a[i][0]) begin errors++; $display("FAIL mid_new_d[%0d] got %b want %0d", i, d, exp_5a[i]); end
      checks++; if ({s0, s1} !== 2'b11) begin errors++; $display("FAIL mid_new_sel[%0d] got %b want 11", i, {s0, s1}); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_new_done got %b want 1", done); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_new_cnt got %0d want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_reset_mid_data();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
